// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/handshake inputs and stall/flush outputs of the
// pipeline sequencer. The master drives requests; the slave (pipe_ctrl)
// returns the stall/flush controls.
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        mc_req_i;
  logic        mc_done_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_start_o;
  logic        mc_abort_o;
  logic [31:0] stall_cnt_o;
  logic        wdog_o;

  modport master (
    output stallreq_from_id, stallreq_from_ex, mc_req_i, mc_done_i,
           excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, mc_start_o, mc_abort_o, stall_cnt_o, wdog_o
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, mc_req_i, mc_done_i,
           excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, mc_start_o, mc_abort_o, stall_cnt_o, wdog_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage core.
// Priority: exception > watchdog > multi-cycle op > EX stall > ID stall.
// Optional watchdog enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE   = 32'h0000_000e,
  parameter logic [15:0] WDOG_LIMIT  = 16'd1024,
  parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN,
    MC_WAIT
  } state_e;

  localparam logic [5:0] STALL_TO_EX = 6'b001111;
  localparam logic [5:0] STALL_TO_ID = 6'b000111;

  state_e      state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        mc_start_c;
  logic        mc_abort_c;
  logic        wdog_c;
  logic        exc_present;
  logic        wdog_trip;

  assign exc_present = (bus.excepttype_i != '0);

`ifdef PIPE_CTRL_WDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;

  assign wdog_trip = (wdog_cnt_q == WDOG_LIMIT);

  // Watchdog counts consecutive stalled cycles; any free-running or flush cycle clears it
  always_comb begin
    wdog_cnt_d = wdog_cnt_q + 16'd1;
    if (rst || (stall_c == '0) || flush_c) begin
      wdog_cnt_d = '0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    wdog_cnt_q <= wdog_cnt_d;
  end
`else
  // Watchdog absent: never trips
  assign wdog_trip = 1'b0 && (WDOG_LIMIT != 16'd0);
`endif

  // Next-state and combinational pipeline controls, in priority order
  always_comb begin
    state_d    = state_q;
    stall_c    = '0;
    flush_c    = 1'b0;
    new_pc_c   = '0;
    mc_start_c = 1'b0;
    mc_abort_c = 1'b0;
    wdog_c     = 1'b0;

    if (rst) begin
      state_d = RUN;
    end else if (exc_present) begin
      flush_c    = 1'b1;
      new_pc_c   = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
      mc_abort_c = (state_q == MC_WAIT);
      state_d    = RUN;
    end else if (wdog_trip) begin
      flush_c    = 1'b1;
      new_pc_c   = WDOG_VECTOR;
      wdog_c     = 1'b1;
      mc_abort_c = (state_q == MC_WAIT);
      state_d    = RUN;
    end else begin
      unique case (state_q)
        MC_WAIT: begin
          if (bus.mc_done_i) begin
            state_d = RUN;
          end else begin
            stall_c = STALL_TO_EX;
          end
        end
        default: begin
          if (bus.mc_req_i) begin
            stall_c    = STALL_TO_EX;
            mc_start_c = 1'b1;
            state_d    = MC_WAIT;
          end else if (bus.stallreq_from_ex) begin
            stall_c = STALL_TO_EX;
          end else if (bus.stallreq_from_id) begin
            stall_c = STALL_TO_ID;
          end
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
    end else if (stall_c[0] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State and stall counter registers
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall       = stall_c;
  assign bus.flush       = flush_c;
  assign bus.new_pc      = new_pc_c;
  assign bus.mc_start_o  = mc_start_c;
  assign bus.mc_abort_o  = mc_abort_c;
  assign bus.wdog_o      = wdog_c;
  assign bus.stall_cnt_o = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned WL = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR  (32'h0000_0020),
    .ERET_CODE   (32'h0000_000e),
    .WDOG_LIMIT  (16'd8),
    .WDOG_VECTOR (32'h0000_0040)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: "a multi-cycle op is in flight", cycles the PC has been held,
  // and the length of the current unbroken stall run.
  bit      m_busy;
  longint  m_cnt;
  int      m_run;

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush, e_start, e_abort, e_wdog;
    logic [31:0] e_pc, e_cnt;
    e_stall = '0; e_flush = 0; e_start = 0; e_abort = 0; e_wdog = 0; e_pc = '0;
    e_cnt = rst ? 32'd0 : 32'(m_cnt);
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_run = 0;
    end else begin
      if (bus.excepttype_i != 0) begin
        e_flush = 1;
        e_pc    = (bus.excepttype_i == 32'he) ? bus.cp0_epc_i : 32'h20;
        e_abort = m_busy;
        m_busy  = 0;
      end else if (WD_EN && m_run == WL) begin
        e_flush = 1; e_pc = 32'h40; e_wdog = 1; e_abort = m_busy; m_busy = 0;
      end else if (m_busy) begin
        if (bus.mc_done_i) m_busy = 0;
        else e_stall = 6'b001111;
      end else if (bus.mc_req_i) begin
        e_stall = 6'b001111; e_start = 1; m_busy = 1;
      end else if (bus.stallreq_from_ex) e_stall = 6'b001111;
      else if (bus.stallreq_from_id) e_stall = 6'b000111;
      if (e_stall[0] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_run = (e_stall == 0 || e_flush) ? 0 : m_run + 1;
    end
    chk("m_stall",  32'(bus.stall),      32'(e_stall));
    chk("m_flush",  32'(bus.flush),      32'(e_flush));
    chk("m_new_pc", bus.new_pc,          e_pc);
    chk("m_start",  32'(bus.mc_start_o), 32'(e_start));
    chk("m_abort",  32'(bus.mc_abort_o), 32'(e_abort));
    chk("m_wdog",   32'(bus.wdog_o),     32'(e_wdog));
    chk("m_cnt",    bus.stall_cnt_o,     e_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.stallreq_from_id = 0; bus.stallreq_from_ex = 0;
    bus.mc_req_i = 0; bus.mc_done_i = 0;
    bus.excepttype_i = '0; bus.cp0_epc_i = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    idle();
    // Reset with active requests: everything reads 0
    rst = 1; bus.stallreq_from_ex = 1; bus.excepttype_i = 32'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_pc", bus.new_pc, 32'd0);
      chk("rst_cnt", bus.stall_cnt_o, 32'd0);
    end
    next(); rst = 0; idle();
    @(negedge clk); chk("post_rst_stall", 32'(bus.stall), 32'd0);

    // ID stall for 3 cycles
    next(); bus.stallreq_from_id = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("id_stall", 32'(bus.stall), 32'h07);
      if (i < 2) next();
    end
    next(); bus.stallreq_from_ex = 1;
    @(negedge clk);
    chk("id_cnt3", bus.stall_cnt_o, 32'd3);
    chk("both_stall", 32'(bus.stall), 32'h0f);

    // Multi-cycle op: done at cycle 5
    next(); idle(); bus.mc_req_i = 1;
    for (int c = 0; c < 6; c++) begin
      bus.mc_done_i = (c == 5);
      @(negedge clk);
      chk("mc_start", 32'(bus.mc_start_o), (c == 0) ? 32'd1 : 32'd0);
      chk("mc_stall", 32'(bus.stall), (c < 5) ? 32'h0f : 32'h00);
      next();
    end
    idle();
    @(negedge clk); chk("mc_back_run", 32'(bus.stall), 32'd0);

    // Exception at cycle 2 of a multi-cycle wait
    next(); bus.mc_req_i = 1;
    @(negedge clk); next();
    @(negedge clk); next();
    bus.excepttype_i = 32'h1;
    @(negedge clk);
    chk("exc_flush", 32'(bus.flush), 32'd1);
    chk("exc_stall", 32'(bus.stall), 32'd0);
    chk("exc_pc", bus.new_pc, 32'h20);
    chk("exc_abort", 32'(bus.mc_abort_o), 32'd1);
    next(); idle();
    @(negedge clk);
    chk("exc_after_stall", 32'(bus.stall), 32'd0);
    chk("exc_after_flush", 32'(bus.flush), 32'd0);

    // ERET redirect
    next(); bus.excepttype_i = 32'he; bus.cp0_epc_i = 32'h0000_1234;
    @(negedge clk);
    chk("eret_flush", 32'(bus.flush), 32'd1);
    chk("eret_pc", bus.new_pc, 32'h1234);
    next(); idle();
    @(negedge clk);
    chk("eret_after_flush", 32'(bus.flush), 32'd0);
    chk("eret_after_pc", bus.new_pc, 32'd0);

    // Long EX stall: watchdog trips on the 9th cycle when built in
    next(); bus.stallreq_from_ex = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (WD_EN && c == 9) begin
        chk("wd_trip", 32'(bus.wdog_o), 32'd1);
        chk("wd_flush", 32'(bus.flush), 32'd1);
        chk("wd_pc", bus.new_pc, 32'h40);
      end else begin
        chk("wd_stall", 32'(bus.stall), 32'h0f);
        chk("wd_quiet", 32'(bus.wdog_o), 32'd0);
      end
      next();
    end
    idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst                  = ($urandom_range(199) == 0);
      bus.stallreq_from_id = ($urandom_range(99) < 30);
      bus.stallreq_from_ex = ($urandom_range(99) < 25);
      bus.mc_req_i         = ($urandom_range(99) < 30);
      bus.mc_done_i        = ($urandom_range(99) < 15);
      bus.cp0_epc_i        = $urandom;
      case ($urandom_range(39))
        0:       bus.excepttype_i = 32'he;
        1:       bus.excepttype_i = 32'($urandom_range(255, 1));
        default: bus.excepttype_i = '0;
      endcase
      next();
    end
    rst = 0; idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It collects stall requests from ID and EX and runs the multi-cycle EX-unit handshake (divider class). It also turns exceptions from the MEM/CP0 path into a one-cycle flush with a redirect PC. Outputs drive stall[5:0] into pc_reg/if_id/id_ex/ex_mem/mem_wb, plus flush and new_pc.

Parameters:
EXC_VECTOR, 32'h00000020, redirect PC for any exception other than ERET
ERET_CODE, 32'h0000000e, excepttype_i value meaning ERET (redirect to cp0_epc_i)
WDOG_LIMIT, 16'd1024, consecutive stalled cycles that trip the watchdog (feature only)
WDOG_VECTOR, 32'h00000040, redirect PC on watchdog trip (feature only)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
stallreq_from_id  in  1  ID hazard stall request
stallreq_from_ex  in  1  EX single-cycle stall request
mc_req_i  in  1  EX holds a multi-cycle op; level, held while the op sits in EX
mc_done_i  in  1  multi-cycle unit result valid (1-cycle pulse)
excepttype_i  in  32  exception code from MEM/CP0; 0 = none
cp0_epc_i  in  32  EPC for ERET
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold stage
flush  out  1  clear all pipeline registers this cycle
new_pc  out  32  redirect target; valid only while flush=1, else 0
mc_start_o  out  1  1-cycle pulse: start multi-cycle unit
mc_abort_o  out  1  1-cycle pulse: kill multi-cycle unit
stall_cnt_o  out  32  saturating count of cycles with stall[0]=1
wdog_o  out  1  1-cycle watchdog trip pulse

Behaviour:
- One clock; reset is synchronous and active-high.
- Registered state: two states RUN and MC_WAIT, plus stall_cnt and watchdog count.
- stall, flush, new_pc, mc_start_o, mc_abort_o and wdog_o are combinational from the current state and inputs, so there is no added latency.
- While rst=1, all outputs are 0 and the next state is RUN with counters cleared.
- Priority, highest first: exception > watchdog > multi-cycle > EX stall > ID stall.
- Exception (excepttype_i != 0), in any state: flush=1, stall=6'b000000.
  - new_pc = cp0_epc_i if excepttype_i == ERET_CODE, else EXC_VECTOR.
  - mc_abort_o=1 if the state is MC_WAIT.
  - Next state RUN.
- RUN, mc_req_i=1: stall=6'b001111, mc_start_o=1, next state MC_WAIT.
- MC_WAIT, mc_done_i=0: stall=6'b001111; mc_req_i is ignored.
- MC_WAIT, mc_done_i=1: stall=0 so EX advances with the result this cycle; next state RUN.
  - A back-to-back multi-cycle op enters EX next cycle and restarts normally.
- RUN, stallreq_from_ex=1: stall=6'b001111. MEM receives a bubble because stall[3]=1 and stall[4]=0.
- RUN, stallreq_from_id=1 (EX not stalling): stall=6'b000111.
- RUN, no requests: stall=0.
- mc_done_i in RUN: ignored. mc_done_i coincident with an exception: the exception wins and abort is asserted.
- stall_cnt_o: +1 on each cycle with stall[0]=1 and rst=0; holds at 32'hFFFFFFFF; cleared only by rst.
- flush is never asserted for two consecutive cycles from a single excepttype_i pulse; the upstream source drops the code after the flush.

Optional Feature:
PIPE_CTRL_WDOG_EN
- Defined:
  - A 16-bit counter increments each cycle with stall != 0 and clears on any cycle with stall == 0 or flush=1.
  - When the counter equals WDOG_LIMIT and no exception is present, that cycle is forced to flush=1, stall=0, new_pc=WDOG_VECTOR, wdog_o=1.
  - mc_abort_o=1 if the state is MC_WAIT; next state RUN; counter cleared.
- Not defined: no counter is built, wdog_o is tied 0, and stalls may last indefinitely.

Test Plan:
- Reset: rst=1 for 2 cycles with stallreq_from_ex=1 and excepttype_i=5 -> stall=0, flush=0, new_pc=0, stall_cnt_o=0. After release with inputs 0 -> stall=0.
- ID/EX stall: stallreq_from_id=1 for 3 cycles -> stall=6'b000111 for 3 cycles and stall_cnt_o=3. Both requests high -> 6'b001111.
- Multi-cycle op: mc_req_i=1 at cycle 0, mc_done_i pulse at cycle 5 -> mc_start_o=1 at cycle 0 only; stall=6'b001111 for cycles 0-4; stall=0 at cycle 5; state RUN at cycle 6.
- Exception during MC_WAIT: excepttype_i=32'h1 at cycle 2 of a multi-cycle wait -> flush=1, stall=0, new_pc=32'h00000020, mc_abort_o=1 in that cycle. Next cycle, with mc_req_i=0 -> stall=0, flush=0.
- ERET: excepttype_i=32'h0000000e with cp0_epc_i=32'h0000_1234 -> flush=1, new_pc=32'h00001234 for one cycle.
- Watchdog (macro defined, WDOG_LIMIT=8): stallreq_from_ex held high -> stall=6'b001111 for 8 cycles, then wdog_o=1, flush=1, new_pc=32'h00000040 on the 9th cycle; the stall pattern resumes afterwards. With the macro undefined -> the stall persists and wdog_o stays 0.
